// File: rtl/t5_wbarb.sv
// t5_wbarb: two-way Wishbone arbiter for the barrel core's fetch (iwb) and
// load/store (dwb) ports onto one shared memory port (mwb). Round-robin grant,
// back-to-back hand-off, combinational ack/read-data pass-through, and a
// pipeline enable (sena) held low while any request waits for its ack.
// Optional ack timeout: define T5_ARB_TMO_EN (uses parameter TMO).
module t5_wbarb #(
  parameter int unsigned TMO = 16
) (
  input  logic        sclk,
  input  logic        srst,
  input  logic        iwb_stb,
  input  logic [29:0] iwb_adr,
  output logic [31:0] iwb_dat,
  output logic        iwb_ack,
  input  logic        dwb_stb,
  input  logic        dwb_wre,
  input  logic [3:0]  dwb_sel,
  input  logic [29:0] dwb_adr,
  input  logic [31:0] dwb_dto,
  output logic [31:0] dwb_dti,
  output logic        dwb_ack,
  output logic        mwb_stb,
  output logic        mwb_wre,
  output logic [3:0]  mwb_sel,
  output logic [29:0] mwb_adr,
  output logic [31:0] mwb_dto,
  input  logic [31:0] mwb_dti,
  input  logic        mwb_ack,
  output logic        sena,
  output logic        arb_err
);

  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

  state_t state, state_n;
  logic   lgnt;     // 1: last grant went to fetch, 0: to data
  logic   tmo_hit;  // timeout expired this cycle with no bus ack
  logic   done;     // current transfer completes this cycle
  logic   grant;    // a new transfer is launched at the coming edge

  if (TMO < 2 || TMO > 255) begin : g_tmo_range
    $error("t5_wbarb: TMO must be within 2..255");
  end

`ifdef T5_ARB_TMO_EN
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);
  logic [7:0] cnt;

  // Ack timeout counter: restarts on every grant, counts un-acked grant cycles.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst)
      cnt <= '0;
    else if (grant)
      cnt <= '0;
    else if (state != IDLE && !mwb_ack)
      cnt <= cnt + 8'd1;
  end

  // A real ack on the expiry cycle takes priority over the timeout.
  always_comb tmo_hit = (state != IDLE) && (cnt == TMO_LAST) && !mwb_ack;
`else
  // No timeout: the arbiter waits for the slave indefinitely.
  always_comb tmo_hit = 1'b0;
`endif

  // Transfer completion and launch qualifiers.
  always_comb begin
    done  = (state != IDLE) && (mwb_ack || tmo_hit);
    grant = (state_n != IDLE) && ((state == IDLE) || done);
  end

  // State register.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state: round-robin from IDLE, direct hand-off to the other port on ack.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (iwb_stb && dwb_stb) state_n = lgnt ? DGNT : IGNT;
        else if (iwb_stb)       state_n = IGNT;
        else if (dwb_stb)       state_n = DGNT;
      end
      IGNT:    if (done) state_n = dwb_stb ? DGNT : IDLE;
      DGNT:    if (done) state_n = iwb_stb ? IGNT : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Bus request register: latch the winner's fields on each grant, hold until done.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      lgnt    <= 1'b1;
      mwb_stb <= 1'b0;
      mwb_wre <= 1'b0;
      mwb_sel <= '0;
      mwb_adr <= '0;
      mwb_dto <= '0;
    end else if (grant) begin
      mwb_stb <= 1'b1;
      if (state_n == IGNT) begin
        lgnt    <= 1'b1;
        mwb_wre <= 1'b0;
        mwb_sel <= '1;
        mwb_adr <= iwb_adr;
        mwb_dto <= '0;
      end else begin
        lgnt    <= 1'b0;
        mwb_wre <= dwb_wre;
        mwb_sel <= dwb_sel;
        mwb_adr <= dwb_adr;
        mwb_dto <= dwb_dto;
      end
    end else if (done) begin
      mwb_stb <= 1'b0;
    end
  end

  // Outputs: acks and read data pass straight through to the granted port.
  always_comb begin
    iwb_ack = (state == IGNT) && (mwb_ack || tmo_hit);
    dwb_ack = (state == DGNT) && (mwb_ack || tmo_hit);
    iwb_dat = (tmo_hit && state == IGNT) ? '0 : mwb_dti;
    dwb_dti = (tmo_hit && state == DGNT) ? '0 : mwb_dti;
    arb_err = tmo_hit;
    sena    = ~((iwb_stb & ~iwb_ack) | (dwb_stb & ~dwb_ack));
  end

endmodule

// File: tb/tb_t5_wbarb.sv
// Testbench for t5_wbarb: directed scenarios plus randomized traffic checked
// against a transaction-level model of the round-robin arbitration rules.
module tb_t5_wbarb;

  localparam int unsigned TMO_TB = 16;

  logic        sclk = 1'b0;
  logic        srst;
  logic        iwb_stb;
  logic [29:0] iwb_adr;
  logic [31:0] iwb_dat;
  logic        iwb_ack;
  logic        dwb_stb;
  logic        dwb_wre;
  logic [3:0]  dwb_sel;
  logic [29:0] dwb_adr;
  logic [31:0] dwb_dto;
  logic [31:0] dwb_dti;
  logic        dwb_ack;
  logic        mwb_stb;
  logic        mwb_wre;
  logic [3:0]  mwb_sel;
  logic [29:0] mwb_adr;
  logic [31:0] mwb_dto;
  logic [31:0] mwb_dti;
  logic        mwb_ack;
  logic        sena;
  logic        arb_err;

  t5_wbarb #(.TMO(TMO_TB)) dut (
    .sclk(sclk), .srst(srst),
    .iwb_stb(iwb_stb), .iwb_adr(iwb_adr), .iwb_dat(iwb_dat), .iwb_ack(iwb_ack),
    .dwb_stb(dwb_stb), .dwb_wre(dwb_wre), .dwb_sel(dwb_sel), .dwb_adr(dwb_adr),
    .dwb_dto(dwb_dto), .dwb_dti(dwb_dti), .dwb_ack(dwb_ack),
    .mwb_stb(mwb_stb), .mwb_wre(mwb_wre), .mwb_sel(mwb_sel), .mwb_adr(mwb_adr),
    .mwb_dto(mwb_dto), .mwb_dti(mwb_dti), .mwb_ack(mwb_ack),
    .sena(sena), .arb_err(arb_err)
  );

  always #5 sclk = ~sclk;

  int tests = 0;
  int fails = 0;

  // Reference model state: bus owner 0=none 1=fetch 2=data, last grant, requests.
  int          owner;
  bit          last_i;
  bit          i_pend, d_pend;
  logic [29:0] ri_adr, rd_adr;
  logic        rd_wre;
  logic [3:0]  rd_sel;
  logic [31:0] rd_dto, dti_v;
  int          last_ack_port;
  int          n_acks;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Holds reset for two cycles, checks reset outputs, returns at a falling edge.
  task automatic reset_dut();
    srst = 1'b1;
    iwb_stb = 1'b0; iwb_adr = '0;
    dwb_stb = 1'b0; dwb_wre = 1'b0; dwb_sel = '0; dwb_adr = '0; dwb_dto = '0;
    mwb_ack = 1'b0; mwb_dti = '0;
    @(negedge sclk); #1;
    check("rst_stb", mwb_stb, 0);
    check("rst_wre", mwb_wre, 0);
    check("rst_sel", mwb_sel, 0);
    check("rst_adr", mwb_adr, 0);
    check("rst_dto", mwb_dto, 0);
    check("rst_err", arb_err, 0);
    check("rst_sena", sena, 1);
    @(negedge sclk);
    srst = 1'b0;
    owner = 0; last_i = 1'b1; i_pend = 1'b0; d_pend = 1'b0;
    last_ack_port = 0; n_acks = 0;
  endtask

  // Random traffic against the model. p: request probability in percent,
  // imm: slave acks every strobe at once, alt: require strictly alternating acks.
  task automatic run(input int n, input int unsigned p, input bit imm, input bit alt);
    int  nxt;
    int  port;
    bit  exp_i, exp_d;
    for (int c = 0; c < n; c++) begin
      if (!i_pend && $urandom_range(99) < p) begin
        i_pend = 1'b1; ri_adr = 30'($urandom);
      end
      if (!d_pend && $urandom_range(99) < p) begin
        d_pend = 1'b1; rd_adr = 30'($urandom); rd_wre = 1'($urandom);
        rd_sel = 4'($urandom); rd_dto = $urandom;
      end
      iwb_stb = i_pend; iwb_adr = ri_adr;
      dwb_stb = d_pend; dwb_adr = rd_adr; dwb_wre = rd_wre; dwb_sel = rd_sel; dwb_dto = rd_dto;
      dti_v = $urandom; mwb_dti = dti_v;
      if (imm) mwb_ack = mwb_stb;
      else     mwb_ack = mwb_stb ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      #1;
      exp_i = (owner == 1) && mwb_ack;
      exp_d = (owner == 2) && mwb_ack;
      check("m_stb", mwb_stb, (owner != 0));
      check("m_iack", iwb_ack, exp_i);
      check("m_dack", dwb_ack, exp_d);
      check("m_sena", sena, !((i_pend && !exp_i) || (d_pend && !exp_d)));
      check("m_err", arb_err, 0);
      if (owner == 1) begin
        check("m_iadr", mwb_adr, ri_adr);
        check("m_iwre", mwb_wre, 0);
        check("m_isel", mwb_sel, 4'hF);
        check("m_idto", mwb_dto, 0);
      end else if (owner == 2) begin
        check("m_dadr", mwb_adr, rd_adr);
        check("m_dwre", mwb_wre, rd_wre);
        check("m_dsel", mwb_sel, rd_sel);
        check("m_ddto", mwb_dto, rd_dto);
      end
      if (exp_i) check("m_idat", iwb_dat, dti_v);
      if (exp_d) check("m_ddat", dwb_dti, dti_v);
      port = iwb_ack ? 1 : (dwb_ack ? 2 : 0);
      if (port != 0) begin
        if (alt && last_ack_port != 0) check("alt", (port != last_ack_port), 1);
        last_ack_port = port;
        n_acks++;
      end
      nxt = owner;
      if (owner != 0 && mwb_ack) begin
        if (owner == 1) begin i_pend = 1'b0; nxt = d_pend ? 2 : 0; end
        else            begin d_pend = 1'b0; nxt = i_pend ? 1 : 0; end
      end else if (owner == 0) begin
        if (i_pend && d_pend) nxt = last_i ? 2 : 1;
        else if (i_pend)      nxt = 1;
        else if (d_pend)      nxt = 2;
      end
      if (nxt != 0 && nxt != owner) last_i = (nxt == 1);
      owner = nxt;
      @(negedge sclk);
    end
  endtask

  initial begin
    // 1: single fetch, slave acks one cycle after strobe
    reset_dut();
    iwb_stb = 1'b1; iwb_adr = 30'h100; #1;
    check("t1_sena_req", sena, 0);
    check("t1_stb0", mwb_stb, 0);
    @(negedge sclk); #1;
    check("t1_stb", mwb_stb, 1);
    check("t1_adr", mwb_adr, 30'h100);
    check("t1_wre", mwb_wre, 0);
    check("t1_sel", mwb_sel, 4'hF);
    check("t1_noack", iwb_ack, 0);
    check("t1_sena_wait", sena, 0);
    @(negedge sclk); mwb_ack = 1'b1; mwb_dti = 32'hCAFE0123; #1;
    check("t1_ack", iwb_ack, 1);
    check("t1_dat", iwb_dat, 32'hCAFE0123);
    check("t1_dack", dwb_ack, 0);
    check("t1_sena_ack", sena, 1);
    @(negedge sclk); iwb_stb = 1'b0; mwb_ack = 1'b0; #1;
    check("t1_idle", mwb_stb, 0);
    check("t1_ack_pulse", iwb_ack, 0);

    // 2: contention after reset grants data, then hands off to fetch
    reset_dut();
    iwb_stb = 1'b1; iwb_adr = 30'h200;
    dwb_stb = 1'b1; dwb_wre = 1'b1; dwb_adr = 30'h40; dwb_dto = 32'hDEADBEEF; dwb_sel = 4'h3; #1;
    check("t2_sena", sena, 0);
    @(negedge sclk); #1;
    check("t2_adr", mwb_adr, 30'h40);
    check("t2_wre", mwb_wre, 1);
    check("t2_sel", mwb_sel, 4'h3);
    check("t2_dto", mwb_dto, 32'hDEADBEEF);
    @(negedge sclk); mwb_ack = 1'b1; #1;
    check("t2_dack", dwb_ack, 1);
    check("t2_iack0", iwb_ack, 0);
    check("t2_sena_hold", sena, 0);
    @(negedge sclk); dwb_stb = 1'b0; dwb_wre = 1'b0; mwb_ack = 1'b0; #1;
    check("t2_b2b_stb", mwb_stb, 1);
    check("t2_b2b_adr", mwb_adr, 30'h200);
    check("t2_b2b_sel", mwb_sel, 4'hF);
    check("t2_b2b_wre", mwb_wre, 0);
    @(negedge sclk); mwb_ack = 1'b1; #1;
    check("t2_iack", iwb_ack, 1);
    check("t2_dack0", dwb_ack, 0);
    @(negedge sclk); iwb_stb = 1'b0; mwb_ack = 1'b0; #1;
    check("t2_idle", mwb_stb, 0);
    dwb_stb = 1'b1; dwb_adr = 30'h41; dwb_sel = 4'hF;
    @(negedge sclk); #1;
    check("t2_lone_adr", mwb_adr, 30'h41);
    @(negedge sclk); mwb_ack = 1'b1; #1;
    check("t2_lone_ack", dwb_ack, 1);
    @(negedge sclk); dwb_stb = 1'b0; mwb_ack = 1'b0;
    @(negedge sclk);
    iwb_stb = 1'b1; iwb_adr = 30'h300; dwb_stb = 1'b1; dwb_adr = 30'h50;
    @(negedge sclk); #1;
    check("t2_rr_fetch", mwb_adr, 30'h300);

    // 3: continuous requests on both ports with immediate ack
    reset_dut();
    run(20, 100, 1'b1, 1'b1);
    check("t3_count", (n_acks >= 8), 1);

    // randomized traffic with random slave latency
    reset_dut();
    run(400, 40, 1'b0, 1'b0);

    // 4: asynchronous reset during a pending data transfer
    reset_dut();
    dwb_stb = 1'b1; dwb_wre = 1'b1; dwb_adr = 30'h77; dwb_sel = 4'h1; #1;
    @(negedge sclk); #1;
    check("t4_granted", mwb_stb, 1);
    #2 srst = 1'b1; #1;
    check("t4_async", mwb_stb, 0);
    @(negedge sclk); srst = 1'b0; dwb_stb = 1'b0; mwb_ack = 1'b1; #1;
    check("t4_late_d", dwb_ack, 0);
    check("t4_late_i", iwb_ack, 0);

    // 6: ack held high in IDLE with no requests
    for (int c = 0; c < 4; c++) begin
      @(negedge sclk); #1;
      check("t6_iack", iwb_ack, 0);
      check("t6_dack", dwb_ack, 0);
      check("t6_sena", sena, 1);
      check("t6_stb", mwb_stb, 0);
    end

    // 5: slave never acks a fetch
`ifdef T5_ARB_TMO_EN
    for (int v = 0; v < 2; v++) begin
      reset_dut();
      iwb_stb = 1'b1; iwb_adr = 30'h123; mwb_dti = 32'hA5A5A5A5;
      @(negedge sclk);
      for (int k = 0; k < int'(TMO_TB); k++) begin
        if (k == int'(TMO_TB) - 1 && v == 1) mwb_ack = 1'b1;
        #1;
        if (k == int'(TMO_TB) - 1) begin
          check("t5_ack", iwb_ack, 1);
          check("t5_err", arb_err, (v == 0));
          check("t5_dat", iwb_dat, (v == 0) ? 32'h0 : 32'hA5A5A5A5);
        end else begin
          check("t5_wait_ack", iwb_ack, 0);
          check("t5_wait_err", arb_err, 0);
          check("t5_wait_stb", mwb_stb, 1);
        end
        @(negedge sclk);
      end
      iwb_stb = 1'b0; mwb_ack = 1'b0; #1;
      check("t5_drop", mwb_stb, 0);
      check("t5_err_pulse", arb_err, 0);
    end
`else
    reset_dut();
    iwb_stb = 1'b1; iwb_adr = 30'h123;
    for (int k = 0; k < int'(TMO_TB) + 8; k++) begin
      @(negedge sclk); #1;
      check("t5_stall_ack", iwb_ack, 0);
      check("t5_stall_err", arb_err, 0);
    end
    check("t5_stall_stb", mwb_stb, 1);
    check("t5_stall_sena", sena, 0);
`endif
    reset_dut();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
